adder_mp_seq: RTL
=================

# adder_mp_seq

Multi-precision sequential adder that sits directly upstream of the 32-bit carry-lookahead adder (`adder_cla`) and consumes its result. Operands wider than NBIT stream in one word per cycle, least-significant first. The block drives the CLA's `i_a`/`i_b`/`i_c` and captures `o_s`/`o_c` into a registered output stage. It carries the CLA's `o_c` into the next word, so an N-word addition completes at one word per cycle behind a valid/ready handshake.

## Interface
- NBIT, 32: word width; must match the CLA width.
- MAXW, 8: maximum words per operation; power of two, at least 2.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rstn  in  1  synchronous active-low reset.
- i_valid  in  1  an input word is offered.
- o_ready  out  1  block can accept a word this cycle.
- i_a, i_b  in  NBIT  operand words.
- i_c  in  1  carry-in; used only on the first word of an operation.
- i_first  in  1  the offered word starts a new operation.
- i_last  in  1  the offered word ends the operation.
- o_valid  out  1  an output word is held.
- i_ready  in  1  the downstream stage takes the output word.
- o_s  out  NBIT  sum word.
- o_c  out  1  carry-out of this word; the final carry when `o_last` is 1.
- o_last  out  1  this output word ends the operation.
- o_idx  out  $clog2(MAXW)  word index within the operation; 0 = least significant.
- o_err  out  1  the operation was force-terminated at MAXW words.

## Operation
- An input word is accepted when `i_valid && o_ready`.
- `o_ready = !o_valid || i_ready` (combinational). This gives full throughput with a single output register.
- FSM states:
  - IDLE: no operation open.
  - BUSY: an operation is open and its carry is held in `cry_q`.
- Carry-in to the CLA is `(state==IDLE || i_first) ? i_c : cry_q`.
- A word with `i_first` while in BUSY aborts the open operation silently and restarts with `i_c`; the word index resets to 0.
- A word without `i_first` while in IDLE is treated as a first word.
- On every accepted word:
  - `o_s`, `o_c` and `o_idx` are registered, and `o_valid` is set.
  - `cry_q` is loaded with the CLA's `o_c`.
  - The word counter increments.
- Effective last = `i_last || (idx == MAXW-1)`.
  - On an effective last: `o_last` = 1, state goes to IDLE, the word counter clears, and `cry_q` clears.
  - If the word was forced last (`i_last` = 0), `o_err` = 1 on that output word; otherwise `o_err` = 0.
- If `o_valid && !i_ready`, all outputs hold stable and no input is accepted.
- If `o_valid && i_ready` with no new accept, `o_valid` goes to 0 next cycle. The data outputs hold their last value.
- Arithmetic is unsigned modulo 2^NBIT per word. Carry propagates only through `cry_q`, never combinationally across words.

## Timing
- Reset values (when `i_rstn` = 0 at a rising edge):
  - `o_valid`, `o_s`, `o_c`, `o_last`, `o_idx`, `o_err` = 0.
  - State = IDLE; `cry_q` = 0; word counter = 0.
  - `o_ready` = 1 the cycle after reset.
- Reset asserted mid-operation discards the operation and any held output word. No partial result is flushed.
- Latency: one cycle from accept to `o_valid`.
- Throughput: one word per cycle while `i_ready` stays high.
- Simultaneous output drain and new accept in the same cycle: the new word replaces the old one and `o_valid` stays 1.
- With a single-word operation (`i_first` and `i_last` both 1), state never leaves IDLE.

## Configuration
- Macro: ADDER_MP_OVF_EN.
- Defined: adds output `o_ovf` (1 bit, reset 0). It equals the two's-complement signed overflow of the top word, `(a[N-1]==b[N-1]) && (s[N-1]!=a[N-1])`, registered with the last word and 0 on non-last words.
- Undefined: the `o_ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package/header `adder_mp_pkg`:
  - NBIT default;
  - state encoding (IDLE=0, BUSY=1);
  - index-width constant derived from MAXW.
- Exactly one sub-module: `adder_cla`, instantiated once as the combinational datapath.
- Everything else lives in `adder_mp_seq`: FSM, carry register, counter, output register.

## Test plan
- Reset while `o_valid` = 1 mid-operation → all outputs 0 next cycle, `o_ready` = 1, state IDLE.
- Single word, `i_first` = `i_last` = 1, a=0xFFFF_FFFF, b=1, `i_c`=0 → one cycle later o_s=0, o_c=1, o_last=1, o_idx=0, o_err=0.
- Two-word add of 0x0000_0001_FFFF_FFFF + 0x0000_0000_0000_0001, `i_c`=0 → word 0: o_s=0, o_c=1; word 1: o_s=2, o_c=0, o_last=1.
- Backpressure: `i_ready` held 0 for 3 cycles with `o_valid` = 1 → `o_ready` = 0, outputs stable, no word lost. Release → stream resumes in order at one word per cycle.
- Nine words with `i_last` never set (MAXW=8) → word 7 has o_last=1, o_err=1. Word 8 starts a new operation with o_idx=0 and carry-in from `i_c`.
- `i_first` reasserted at word 2 of an open operation → o_idx=0, carry-in = `i_c`. With ADDER_MP_OVF_EN: 0x7FFF_FFFF + 1 as a last word → o_ovf=1.

Source files
------------

// File: rtl/adder_mp_pkg.sv
// Shared constants and types for the multi-precision sequential adder.
// Provides the default word width, FSM state encoding and index-width helper.
package adder_mp_pkg;

  localparam int NBIT_DEF = 32;
  localparam int MAXW_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int idx_w(input int maxw);
    return (maxw > 1) ? $clog2(maxw) : 1;
  endfunction

  localparam int IDXW_DEF = idx_w(MAXW_DEF);

endpackage

// File: rtl/adder_cla.sv
// Combinational carry-lookahead adder built from 4-bit lookahead groups.
// NBIT must be a multiple of 4.
module adder_cla
  import adder_mp_pkg::*;
#(
  parameter int NBIT = NBIT_DEF
) (
  input  logic [NBIT-1:0] i_a,
  input  logic [NBIT-1:0] i_b,
  input  logic            i_c,
  output logic [NBIT-1:0] o_s,
  output logic            o_c
);

  localparam int NG = NBIT / 4;

  logic [NBIT-1:0] gen;
  logic [NBIT-1:0] prp;
  logic [NBIT-1:0] cin_bit;
  logic [NG:0]     cin_grp;
  logic            grp_g;
  logic            grp_p;
  logic            cc;

  always_comb begin
    gen        = i_a & i_b;
    prp        = i_a ^ i_b;
    cin_grp    = '0;
    cin_bit    = '0;
    grp_g      = 1'b0;
    grp_p      = 1'b1;
    cc         = 1'b0;
    cin_grp[0] = i_c;
    // Group generate/propagate give each group's carry-in without rippling bits
    for (int k = 0; k < NG; k++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int j = 0; j < 4; j++) begin
        grp_g = gen[4*k+j] | (prp[4*k+j] & grp_g);
        grp_p = grp_p & prp[4*k+j];
      end
      cin_grp[k+1] = grp_g | (grp_p & cin_grp[k]);
    end
    for (int k = 0; k < NG; k++) begin
      cc = cin_grp[k];
      for (int j = 0; j < 4; j++) begin
        cin_bit[4*k+j] = cc;
        cc = gen[4*k+j] | (prp[4*k+j] & cc);
      end
    end
    o_s = prp ^ cin_bit;
    o_c = cin_grp[NG];
  end

endmodule

// File: rtl/adder_mp_seq.sv
// Multi-precision sequential adder: streams NBIT-bit words LS-first through
// adder_cla, carrying between words. Optional o_ovf port under ADDER_MP_OVF_EN.
module adder_mp_seq
  import adder_mp_pkg::*;
#(
  parameter int NBIT = NBIT_DEF,
  parameter int MAXW = MAXW_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NBIT-1:0]          i_a,
  input  logic [NBIT-1:0]          i_b,
  input  logic                     i_c,
  input  logic                     i_first,
  input  logic                     i_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NBIT-1:0]          o_s,
  output logic                     o_c,
  output logic                     o_last,
  output logic [idx_w(MAXW)-1:0]   o_idx,
  output logic                     o_err
`ifdef ADDER_MP_OVF_EN
  ,
  output logic                     o_ovf
`endif
);

  localparam int IW = idx_w(MAXW);

  state_e          state_q, state_d;
  logic            cry_q, cry_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            o_valid_q, o_valid_d;
  logic [NBIT-1:0] o_s_q, o_s_d;
  logic            o_c_q, o_c_d;
  logic            o_last_q, o_last_d;
  logic [IW-1:0]   o_idx_q, o_idx_d;
  logic            o_err_q, o_err_d;
  logic            o_ovf_q, o_ovf_d;

  logic            accept;
  logic            start;
  logic            cla_cin;
  logic [IW-1:0]   idx_cur;
  logic            eff_last;
  logic [NBIT-1:0] cla_s;
  logic            cla_c;
  logic            ovf_now;

  assign o_ready  = !o_valid_q || i_ready;
  assign accept   = i_valid && o_ready;
  assign start    = (state_q == IDLE) || i_first;
  assign cla_cin  = start ? i_c : cry_q;
  assign idx_cur  = start ? '0 : cnt_q;
  assign eff_last = i_last || (idx_cur == IW'(MAXW - 1));
  assign ovf_now  = (i_a[NBIT-1] == i_b[NBIT-1]) && (cla_s[NBIT-1] != i_a[NBIT-1]);

  adder_cla #(.NBIT(NBIT)) u_cla (
    .i_a (i_a),
    .i_b (i_b),
    .i_c (cla_cin),
    .o_s (cla_s),
    .o_c (cla_c)
  );

  always_comb begin
    state_d   = state_q;
    cry_d     = cry_q;
    cnt_d     = cnt_q;
    o_valid_d = o_valid_q;
    o_s_d     = o_s_q;
    o_c_d     = o_c_q;
    o_last_d  = o_last_q;
    o_idx_d   = o_idx_q;
    o_err_d   = o_err_q;
    o_ovf_d   = o_ovf_q;
    if (accept) begin
      o_valid_d = 1'b1;
      o_s_d     = cla_s;
      o_c_d     = cla_c;
      o_idx_d   = idx_cur;
      o_last_d  = eff_last;
      o_err_d   = eff_last && !i_last;
      o_ovf_d   = eff_last && ovf_now;
      // Closing word returns to IDLE so the next word restarts from i_c
      if (eff_last) begin
        state_d = IDLE;
        cnt_d   = '0;
        cry_d   = 1'b0;
      end else begin
        state_d = BUSY;
        cnt_d   = idx_cur + IW'(1);
        cry_d   = cla_c;
      end
    end else if (i_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      cry_q     <= 1'b0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_s_q     <= '0;
      o_c_q     <= 1'b0;
      o_last_q  <= 1'b0;
      o_idx_q   <= '0;
      o_err_q   <= 1'b0;
      o_ovf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cry_q     <= cry_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_s_q     <= o_s_d;
      o_c_q     <= o_c_d;
      o_last_q  <= o_last_d;
      o_idx_q   <= o_idx_d;
      o_err_q   <= o_err_d;
      o_ovf_q   <= o_ovf_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_s     = o_s_q;
  assign o_c     = o_c_q;
  assign o_last  = o_last_q;
  assign o_idx   = o_idx_q;
  assign o_err   = o_err_q;
`ifdef ADDER_MP_OVF_EN
  assign o_ovf   = o_ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = o_ovf_q;
`endif

endmodule
